// File: rtl/snake_dir_if.sv
// Key/step/init inputs and direction outputs shared by the snake direction controller and its driver.
// The master side drives buttons and head-step strobes. The slave side is the controller.
interface snake_dir_if;
  logic [3:0] key_n;
  logic       step;
  logic       init;
  logic [2:0] dir;
  logic       turn_pending;
  logic       turn_rejected;

  modport master (
    output key_n, step, init,
    input  dir, turn_pending, turn_rejected
  );

  modport slave (
    input  key_n, step, init,
    output dir, turn_pending, turn_rejected
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Button-to-direction controller: synchronise, debounce, arbitrate, validate and queue turns, commit one per step.
// Macro SNAKE_TURN_QUEUE_EN selects a 2-entry turn FIFO instead of the single overwrite slot.
module snake_dir_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  snake_dir_if.slave bus
);
  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_DOWN  = 3'b110;
  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]                  synced;
  logic [3:0]                  db_q, db_d;
  logic [3:0][CNT_W-1:0]       dcnt_q, dcnt_d;
  logic [3:0]                  press;

  logic       req_vld, req_others, req_ok;
  logic [2:0] req_dir;
  logic [2:0] cur_q, cur_d;
  logic [2:0] head_dir, ref_dir;
  logic       pending;
  logic       rej_q, rej_d;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sync_d[k] = {sync_q[k][SYNC_STAGES-2:0], bus.key_n[k]};
      synced[k] = sync_q[k][SYNC_STAGES-1];
      db_d[k]   = db_q[k];
      dcnt_d[k] = '0;
      if (synced[k] != db_q[k]) begin
        if (dcnt_q[k] == CNT_LAST) db_d[k] = synced[k];
        else                       dcnt_d[k] = dcnt_q[k] + CNT_W'(1);
      end
    end
  end

  // Press fires in the cycle the debounced level falls, so the queue is written on that same edge.
  assign press = db_q & ~db_d;

  always_comb begin
    req_vld    = 1'b1;
    req_dir    = DIR_UP;
    req_others = 1'b0;
    if (press[0]) begin
      req_dir    = DIR_UP;
      req_others = |press[3:1];
    end else if (press[1]) begin
      req_dir    = DIR_DOWN;
      req_others = |press[3:2];
    end else if (press[2]) begin
      req_dir    = DIR_LEFT;
      req_others = press[3];
    end else if (press[3]) begin
      req_dir    = DIR_RIGHT;
    end else begin
      req_vld    = 1'b0;
    end
  end

  assign req_ok = req_vld && (req_dir[2] != ref_dir[2]);

`ifdef SNAKE_TURN_QUEUE_EN
  logic [2:0] q0_q, q0_d, q1_q, q1_d;
  logic [1:0] qcnt_q, qcnt_d;
  logic       pop, push;

  assign head_dir = (qcnt_q != 2'd0) ? q0_q : cur_q;
  assign ref_dir  = (qcnt_q == 2'd2) ? q1_q : head_dir;
  assign pending  = (qcnt_q != 2'd0);
  assign pop      = bus.step && (qcnt_q != 2'd0);
  assign push     = req_ok && ((qcnt_q != 2'd2) || pop);

  always_comb begin
    cur_d  = cur_q;
    q0_d   = q0_q;
    q1_d   = q1_q;
    qcnt_d = qcnt_q;
    rej_d  = 1'b0;
    if (bus.init) begin
      cur_d  = DIR_UP;
      qcnt_d = 2'd0;
    end else begin
      rej_d = req_others || (req_vld && !push);
      if (pop) begin
        cur_d  = q0_q;
        q0_d   = q1_q;
        qcnt_d = qcnt_d - 2'd1;
      end
      if (push) begin
        if (qcnt_d == 2'd0) q0_d = req_dir;
        else                q1_d = req_dir;
        qcnt_d = qcnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0_q   <= DIR_UP;
      q1_q   <= DIR_UP;
      qcnt_q <= 2'd0;
    end else begin
      q0_q   <= q0_d;
      q1_q   <= q1_d;
      qcnt_q <= qcnt_d;
    end
  end
`else
  logic [2:0] slot_q, slot_d;
  logic       full_q, full_d;

  assign head_dir = full_q ? slot_q : cur_q;
  assign ref_dir  = head_dir;
  assign pending  = full_q;

  // A later press validated against the held entry replaces it; the latest press wins.
  always_comb begin
    cur_d  = cur_q;
    slot_d = slot_q;
    full_d = full_q;
    rej_d  = 1'b0;
    if (bus.init) begin
      cur_d  = DIR_UP;
      full_d = 1'b0;
    end else begin
      rej_d = req_others || (req_vld && !req_ok);
      if (bus.step && full_q) begin
        cur_d  = slot_q;
        full_d = 1'b0;
      end
      if (req_ok) begin
        slot_d = req_dir;
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= DIR_UP;
      full_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      full_q <= full_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      db_q   <= '1;
      dcnt_q <= '0;
      cur_q  <= DIR_UP;
      rej_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      dcnt_q <= dcnt_d;
      cur_q  <= cur_d;
      rej_q  <= rej_d;
    end
  end

  assign bus.dir           = head_dir;
  assign bus.turn_pending  = pending;
  assign bus.turn_rejected = rej_q;
endmodule
